// File: rtl/or_bus_event_latch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : or_bus_event_latch_pkg
// Purpose  : Shared constants for the OR-bus sticky event latch: FSM state
//            encoding and the default event-counter width.
// Revision : 1.0 - initial release
// ============================================================================
package or_bus_event_latch_pkg;

  // Two-state interrupt FSM; state register is a single bit.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Default width of the saturating event counter.
  localparam int unsigned COUNT_BITS_DEFAULT = 4;

endpackage : or_bus_event_latch_pkg
`default_nettype wire

// File: rtl/or_bus_event_latch_sync2.sv
`default_nettype none
// ============================================================================
// Module   : or_bus_sync2
// Purpose  : NrOfBits-wide two-flop synchronizer. Each bit is synchronized
//            independently; both stages clear asynchronously on reset.
// Ports    : clock   - destination clock
//            reset_n - asynchronous active-low reset
//            d_i     - asynchronous input bus
//            q_o     - synchronized output bus (two cycles of latency)
// Revision : 1.0 - initial release
// ============================================================================
module or_bus_sync2 #(
  parameter int unsigned NrOfBits = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NrOfBits-1:0] d_i,
  output logic [NrOfBits-1:0] q_o
);

  logic [NrOfBits-1:0] meta_q;
  logic [NrOfBits-1:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : or_bus_sync2
`default_nettype wire

// File: rtl/or_bus_event_latch.sv
`default_nettype none
// ============================================================================
// Module   : or_bus_event_latch
// Purpose  : Sticky event capture downstream of a multi-bit OR bus gate.
//            Detects per-bit rising edges, latches them into sticky pending
//            flags with a registered interrupt, and keeps a saturating count
//            of captured edges with a sticky overflow flag. A level-sampled
//            clear acknowledges events; rises coincident with clear survive.
// Config   : OR_BUS_EVENT_SYNC_EN - when defined, or_result passes through a
//            two-flop synchronizer (adds two cycles of latency); otherwise it
//            is used directly and must already be synchronous to clock.
// Ports    : clock       - clock, rising edge
//            reset_n     - asynchronous active-low reset
//            or_result   - monitored OR bus [NrOfBits]
//            clear       - acknowledge/clear request
//            pending     - sticky per-bit rising-edge flags [NrOfBits]
//            irq         - high while FSM is ACTIVE (registered)
//            event_count - saturating captured-edge count [CountBits]
//            overflow    - sticky count-overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module or_bus_event_latch
  import or_bus_event_latch_pkg::*;
#(
  parameter int unsigned NrOfBits  = 1,
  parameter int unsigned CountBits = COUNT_BITS_DEFAULT  // minimum 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NrOfBits-1:0]  or_result,
  input  logic                 clear,
  output logic [NrOfBits-1:0]  pending,
  output logic                 irq,
  output logic [CountBits-1:0] event_count,
  output logic                 overflow
);

  // Saturation limit held at CountBits+1 bits so it compares directly
  // against the unsaturated sum.
  localparam logic [CountBits:0] CNT_MAX = {1'b0, {CountBits{1'b1}}};

  logic [NrOfBits-1:0]  s_w;
  logic [NrOfBits-1:0]  prev_q;
  logic [NrOfBits-1:0]  rise_w;
  logic [NrOfBits-1:0]  pending_q, pending_d;
  logic [CountBits-1:0] count_q,   count_d;
  logic                 overflow_q, overflow_d;
  logic [0:0]           state_q,   state_d;
  logic [CountBits:0]   n_w;
  logic [CountBits:0]   base_w;
  logic [CountBits:0]   sum_w;
  logic                 sat_hit_w;

  // --------------------------------------------------------------------------
  // Input path
  // --------------------------------------------------------------------------
`ifdef OR_BUS_EVENT_SYNC_EN
  or_bus_sync2 #(
    .NrOfBits (NrOfBits)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d_i     (or_result),
    .q_o     (s_w)
  );
`else
  assign s_w = or_result;
`endif

  // prev resets to 0, so a bit already high when reset releases is one rise.
  assign rise_w = s_w & ~prev_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Popcount of this cycle's rises. Assumes NrOfBits fits in CountBits+1
    // bits; any realistic bus/counter pairing satisfies this.
    n_w = '0;
    for (int i = 0; i < int'(NrOfBits); i++) begin
      n_w = n_w + {{CountBits{1'b0}}, rise_w[i]};
    end

    // Clear restarts the count from this cycle's rises rather than zero,
    // so coincident edges are not lost.
    base_w    = clear ? '0 : {1'b0, count_q};
    sum_w     = base_w + n_w;
    sat_hit_w = (sum_w > CNT_MAX);
    count_d   = sat_hit_w ? CNT_MAX[CountBits-1:0] : sum_w[CountBits-1:0];

    // Clear drops overflow, but the same cycle's rises may re-set it.
    overflow_d = (overflow_q & ~clear) | sat_hit_w;

    pending_d = clear ? rise_w : (pending_q | rise_w);

    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pending_d != '0) state_d = ST_ACTIVE;
      ST_ACTIVE: if (pending_d == '0) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      pending_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      prev_q     <= s_w;
      pending_q  <= pending_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  assign pending     = pending_q;
  assign irq         = (state_q == ST_ACTIVE);
  assign event_count = count_q;
  assign overflow    = overflow_q;

endmodule : or_bus_event_latch
`default_nettype wire

// File: tb/tb_or_bus_event_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_or_bus_event_latch
// Purpose  : Self-checking bench for or_bus_event_latch (NrOfBits=3,
//            CountBits=4). Directed stimulus pushes hand-computed expected
//            outputs, tagged with the clock edge they apply to, into a
//            scoreboard queue; a monitor pops and compares after each edge
//            and on asynchronous-reset probes. Works with or without
//            OR_BUS_EVENT_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_or_bus_event_latch;

`ifdef OR_BUS_EVENT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clock;
  logic       reset_n;
  logic [2:0] or_result;
  logic       clear;
  logic [2:0] pending;
  logic       irq;
  logic [3:0] event_count;
  logic       overflow;

  or_bus_event_latch #(
    .NrOfBits  (3),
    .CountBits (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .or_result   (or_result),
    .clear       (clear),
    .pending     (pending),
    .irq         (irq),
    .event_count (event_count),
    .overflow    (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         due;    // edge index, or -1 for an asynchronous probe
    string      name;
    logic [2:0] pend;
    logic       irq;
    logic [3:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event probe_ev;

  task automatic compare(input exp_t e);
    n_cmp++;
    if ({pending, irq, event_count, overflow} !== {e.pend, e.irq, e.cnt, e.ovf}) begin
      n_bad++;
      $display("FAIL %s: got pend=%b irq=%b cnt=%0d ovf=%b, want pend=%b irq=%b cnt=%0d ovf=%b",
               e.name, pending, irq, event_count, overflow, e.pend, e.irq, e.cnt, e.ovf);
    end
  endtask

  // Monitor: wakes after every edge (and on async probes) and checks every
  // expectation due now.
  initial begin
    forever begin
      @(posedge clock or probe_ev);
      #3;
      while (sb.size() > 0 && (sb[0].due == cyc || sb[0].due < 0)) begin
        compare(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due >= 0 && sb[0].due < cyc) begin
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s: expectation for edge %0d never checked (now %0d)", e.name, e.due, cyc);
      end
    end
  end

  function automatic exp_t mk(input int due, input string nm, input logic [2:0] p,
                              input logic i, input logic [3:0] c, input logic o);
    exp_t e;
    e.due = due; e.name = nm; e.pend = p; e.irq = i; e.cnt = c; e.ovf = o;
    return e;
  endfunction

  // One clock: drive at negedge, optionally expect outputs after the edge.
  task automatic go(input logic [2:0] o, input logic c, input bit chk, input string nm,
                    input logic [2:0] p, input logic i, input logic [3:0] n, input logic v);
    @(negedge clock);
    or_result = o;
    clear     = c;
    if (chk) sb.push_back(mk(cyc + 1, nm, p, i, n, v));
    @(posedge clock);
  endtask

  // Present o, let it propagate through the input path, then on the edge
  // where it takes effect sample clear=c and check the result.
  task automatic apply(input logic [2:0] o, input logic c, input string nm,
                       input logic [2:0] p, input logic i, input logic [3:0] n, input logic v);
    repeat (LAT) go(o, 1'b0, 1'b0, nm, p, i, n, v);
    go(o, c, 1'b1, nm, p, i, n, v);
  endtask

  task automatic async_probe(input string nm);
    sb.push_back(mk(-1, nm, 3'b000, 1'b0, 4'd0, 1'b0));
    ->probe_ev;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    or_result = 3'b000;
    clear     = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    async_probe("reset_hold");
    @(negedge clock);
    reset_n = 1'b1;

    apply(3'b000, 1'b0, "after_reset",     3'b000, 1'b0, 4'd0, 1'b0);
    // Two rises at once, then held: no further counting.
    apply(3'b101, 1'b0, "rise_101",        3'b101, 1'b1, 4'd2, 1'b0);
    apply(3'b101, 1'b0, "hold_101_a",      3'b101, 1'b1, 4'd2, 1'b0);
    apply(3'b101, 1'b0, "hold_101_b",      3'b101, 1'b1, 4'd2, 1'b0);
    apply(3'b101, 1'b1, "clear_no_rise",   3'b000, 1'b0, 4'd0, 1'b0);
    apply(3'b000, 1'b0, "fall_idle",       3'b000, 1'b0, 4'd0, 1'b0);
    apply(3'b001, 1'b0, "rise_bit0",       3'b001, 1'b1, 4'd1, 1'b0);
    // Bit-1 rise coincides with clear and survives it.
    apply(3'b011, 1'b1, "clear_with_rise", 3'b010, 1'b1, 4'd1, 1'b0);
    apply(3'b011, 1'b1, "clear_again",     3'b000, 1'b0, 4'd0, 1'b0);
    apply(3'b000, 1'b0, "drop_all",        3'b000, 1'b0, 4'd0, 1'b0);
    // Toggle to saturation.
    apply(3'b111, 1'b0, "tog_3",           3'b111, 1'b1, 4'd3,  1'b0);
    apply(3'b000, 1'b0, "tog_3_low",       3'b111, 1'b1, 4'd3,  1'b0);
    apply(3'b111, 1'b0, "tog_6",           3'b111, 1'b1, 4'd6,  1'b0);
    apply(3'b000, 1'b0, "tog_6_low",       3'b111, 1'b1, 4'd6,  1'b0);
    apply(3'b111, 1'b0, "tog_9",           3'b111, 1'b1, 4'd9,  1'b0);
    apply(3'b000, 1'b0, "tog_9_low",       3'b111, 1'b1, 4'd9,  1'b0);
    apply(3'b111, 1'b0, "tog_12",          3'b111, 1'b1, 4'd12, 1'b0);
    apply(3'b000, 1'b0, "tog_12_low",      3'b111, 1'b1, 4'd12, 1'b0);
    apply(3'b111, 1'b0, "tog_15",          3'b111, 1'b1, 4'd15, 1'b0);
    apply(3'b000, 1'b0, "tog_15_low",      3'b111, 1'b1, 4'd15, 1'b0);
    apply(3'b111, 1'b0, "tog_sat",         3'b111, 1'b1, 4'd15, 1'b1);
    apply(3'b000, 1'b0, "sat_hold_low",    3'b111, 1'b1, 4'd15, 1'b1);
    apply(3'b111, 1'b0, "sat_hold",        3'b111, 1'b1, 4'd15, 1'b1);
    apply(3'b000, 1'b1, "clear_sat",       3'b000, 1'b0, 4'd0,  1'b0);
    // Clear held over several cycles: each cycle shows only its own rises.
    apply(3'b111, 1'b1, "clr_held_rise",   3'b111, 1'b1, 4'd3,  1'b0);
    apply(3'b111, 1'b1, "clr_held_quiet",  3'b000, 1'b0, 4'd0,  1'b0);
    // Build count 5, then assert reset asynchronously mid-cycle.
    apply(3'b000, 1'b0, "pre5_low",        3'b000, 1'b0, 4'd0,  1'b0);
    apply(3'b101, 1'b0, "pre5_a",          3'b101, 1'b1, 4'd2,  1'b0);
    apply(3'b000, 1'b0, "pre5_b",          3'b101, 1'b1, 4'd2,  1'b0);
    apply(3'b111, 1'b0, "count_5",         3'b111, 1'b1, 4'd5,  1'b0);
    @(negedge clock); #1;
    reset_n = 1'b0;
    async_probe("async_reset");
    go(3'b111, 1'b0, 1'b1, "in_reset_a", 3'b000, 1'b0, 4'd0, 1'b0);
    go(3'b111, 1'b0, 1'b1, "in_reset_b", 3'b000, 1'b0, 4'd0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    // Bus already high at release: every bit counts once.
    apply(3'b111, 1'b0, "high_at_release", 3'b111, 1'b1, 4'd3, 1'b0);
    apply(3'b110, 1'b0, "bit0_fall",       3'b111, 1'b1, 4'd3, 1'b0);
    // Single-cycle pulse on bit 0 counts exactly once.
    go(3'b111, 1'b0, (LAT == 0), "pulse_bit0", 3'b111, 1'b1, 4'd4, 1'b0);
    apply(3'b110, 1'b0, "pulse_after",     3'b111, 1'b1, 4'd4, 1'b0);
    apply(3'b000, 1'b1, "final_clear",     3'b000, 1'b0, 4'd0, 1'b0);

    repeat (3) @(posedge clock);
    #5;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation left unchecked (due edge %0d)", e.name, e.due);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_or_bus_event_latch
`default_nettype wire
